// File: rtl/store_write_controller_if.sv
// Store-side request and memory-side write bundle for store_write_controller.
// The controller takes the slave modport; a core/memory model takes master.
interface store_write_controller_if #(
  parameter int unsigned AW = 32
) ();
  logic          st_valid;
  logic          st_ready;
  logic [AW-1:0] st_addr;
  logic [31:0]   st_data;
  logic          st_sb;
  logic          st_sh;
  logic          st_sw;
  logic          mem_wvalid;
  logic          mem_wready;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_be;

  modport master (
    output st_valid, st_addr, st_data, st_sb, st_sh, st_sw, mem_wready,
    input  st_ready, mem_wvalid, mem_addr, mem_wdata, mem_be
  );

  modport slave (
    input  st_valid, st_addr, st_data, st_sb, st_sh, st_sw, mem_wready,
    output st_ready, mem_wvalid, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/store_write_controller.sv
// Store buffer: lane-replicates and byte-enables core stores, queues them and drains to memory.
// Optional STORE_MISALIGN_CHK_EN drops misaligned sh/sw stores and pulses misalign_err.
module store_write_controller #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  store_write_controller_if.slave bus,
  input  logic                    flush_req,
  output logic                    flush_done,
  input  logic [AW-1:0]           ld_addr,
  output logic                    ld_hazard,
`ifdef STORE_MISALIGN_CHK_EN
  output logic                    misalign_err,
`endif
  output logic [$clog2(DEPTH):0]  occupancy
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StFlushed} state_e;

  state_e        state_q;
  logic          wvalid_q, flush_done_q, flush_pend_q;
  logic [PW-1:0] rd_ptr_q, wr_ptr_q, hz_off;
  logic [CW-1:0] count_q, count_next;
  logic [AW-3:0] waddr_q [DEPTH];
  logic [31:0]   wdata_q [DEPTH];
  logic [3:0]    be_q    [DEPTH];

  logic          is_w, is_h, full, accept, push, pop;
  logic [31:0]   lane_data;
  logic [3:0]    lane_be;
  logic          unused_sig;

  // Byte width is the fallback, so st_sb and the load byte offset never need decoding.
  assign unused_sig = ^{ld_addr[1:0], bus.st_sb};

  always_comb begin
    is_w      = bus.st_sw;
    is_h      = !bus.st_sw && bus.st_sh;
    lane_data = {is_w ? bus.st_data[31:24] : (is_h ? bus.st_data[15:8] : bus.st_data[7:0]),
                 is_w ? bus.st_data[23:16] : bus.st_data[7:0],
                 (is_w || is_h) ? bus.st_data[15:8] : bus.st_data[7:0],
                 bus.st_data[7:0]};
    if (is_w)      lane_be = 4'b1111;
    else if (is_h) lane_be = bus.st_addr[1] ? 4'b1100 : 4'b0011;
    else           lane_be = 4'b0001 << bus.st_addr[1:0];
  end

  assign full         = (count_q == CW'(DEPTH));
  assign bus.st_ready = !full && !flush_pend_q;
  assign accept       = bus.st_valid && bus.st_ready;
  assign pop          = wvalid_q && bus.mem_wready;

`ifdef STORE_MISALIGN_CHK_EN
  logic misalign, misalign_q;
  assign misalign     = (is_w && (bus.st_addr[1:0] != 2'b00)) || (is_h && bus.st_addr[0]);
  assign push         = accept && !misalign;
  assign misalign_err = misalign_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_q <= 1'b0;
    else        misalign_q <= accept && misalign;
  end
`else
  assign push = accept;
`endif

  assign count_next = count_q + CW'(push) - CW'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        waddr_q[i] <= '0;
        wdata_q[i] <= '0;
        be_q[i]    <= '0;
      end
    end else begin
      if (push) begin
        waddr_q[wr_ptr_q] <= bus.st_addr[AW-1:2];
        wdata_q[wr_ptr_q] <= lane_data;
        be_q[wr_ptr_q]    <= lane_be;
        wr_ptr_q          <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_next;
    end
  end

  // Head fields come straight from storage so they hold until the entry pops.
  assign bus.mem_wvalid = wvalid_q;
  assign bus.mem_addr   = {waddr_q[rd_ptr_q], 2'b00};
  assign bus.mem_wdata  = wdata_q[rd_ptr_q];
  assign bus.mem_be     = be_q[rd_ptr_q];
  assign flush_done     = flush_done_q;
  assign occupancy      = count_q;

  always_comb begin
    ld_hazard = 1'b0;
    hz_off    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      hz_off = PW'(i) - rd_ptr_q;
      if (({1'b0, hz_off} < count_q) && (waddr_q[i] == ld_addr[AW-1:2])) ld_hazard = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      wvalid_q     <= 1'b0;
      flush_done_q <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      flush_done_q <= 1'b0;
      if (flush_req) flush_pend_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (count_q != '0) begin
            state_q  <= StIssue;
            wvalid_q <= 1'b1;
          end else if (flush_pend_q) begin
            state_q      <= StFlushed;
            flush_done_q <= 1'b1;
          end
        end
        StIssue: begin
          if (bus.mem_wready && (count_next == '0)) begin
            wvalid_q <= 1'b0;
            if (flush_pend_q) begin
              state_q      <= StFlushed;
              flush_done_q <= 1'b1;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        StFlushed: begin
          // A flush_req landing here is absorbed by the flush being completed.
          state_q      <= StIdle;
          flush_pend_q <= 1'b0;
        end
        default: begin
          state_q  <= StIdle;
          wvalid_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_store_write_controller.sv
// Directed and randomized bench for store_write_controller against a queue-based reference.
// Honours STORE_MISALIGN_CHK_EN the same way the design does.
module tb_store_write_controller;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 32;
`ifdef STORE_MISALIGN_CHK_EN
  localparam bit MIS_CHK = 1'b1;
`else
  localparam bit MIS_CHK = 1'b0;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush_req = 1'b0;
  logic          flush_done;
  logic [AW-1:0] ld_addr = '0;
  logic          ld_hazard;
  logic [2:0]    occupancy;
`ifdef STORE_MISALIGN_CHK_EN
  logic          misalign_err;
`endif

  store_write_controller_if #(.AW(AW)) bus ();

  store_write_controller #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .flush_req  (flush_req),
    .flush_done (flush_done),
    .ld_addr    (ld_addr),
    .ld_hazard  (ld_hazard),
`ifdef STORE_MISALIGN_CHK_EN
    .misalign_err (misalign_err),
`endif
    .occupancy  (occupancy)
  );

  always #5 clk = ~clk;

  ent_t q[$];
  ent_t obs[$];
  int   npass = 0, ntotal = 0;
  int   cyc = 0, last_pop_cyc = 0, fd_cyc = 0, fd_cnt = 0, n_pop = 0;
  bit   pend = 0, exp_mis = 0, last_acc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntotal++;
    assert (got === exp) npass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: what memory must see for one store, from the width/alignment rules.
  function automatic ent_t make_entry(logic [31:0] a, logic [31:0] d, logic sh, logic sw);
    ent_t e;
    e.addr = a & ~32'h3;
    if (sw) begin
      e.data = d;
      e.be   = 4'hF;
    end else if (sh) begin
      e.data = {2{d[15:0]}};
      e.be   = a[1] ? 4'hC : 4'h3;
    end else begin
      e.data = {4{d[7:0]}};
      e.be   = 4'h1 << a[1:0];
    end
    return e;
  endfunction

  function automatic bit is_misaligned(logic [31:0] a, logic sh, logic sw);
    if (sw) return a[1:0] != 2'b00;
    if (sh) return a[0];
    return 1'b0;
  endfunction

  task automatic tick();
    logic acc, pop, mis, hz;
    ent_t e;
    @(negedge clk);
    cyc++;
    chk("st_ready", bus.st_ready, (q.size() < DEPTH) && !pend);
    chk("occupancy", occupancy, q.size());
    hz = 1'b0;
    foreach (q[i]) if (q[i].addr[31:2] == ld_addr[31:2]) hz = 1'b1;
    chk("ld_hazard", ld_hazard, hz);
`ifdef STORE_MISALIGN_CHK_EN
    chk("misalign_err", misalign_err, exp_mis);
`endif
    if (bus.mem_wvalid) begin
      chk("wvalid_nonempty", q.size() != 0, 1);
      if (q.size() != 0) begin
        chk("mem_addr", bus.mem_addr, q[0].addr);
        chk("mem_wdata", bus.mem_wdata, q[0].data);
        chk("mem_be", bus.mem_be, q[0].be);
      end
    end
    if (flush_done) begin
      fd_cnt++;
      fd_cyc = cyc;
      chk("flush_done_ctx", {pend, q.size() == 0}, 2'b11);
    end
    acc = bus.st_valid && bus.st_ready;
    pop = bus.mem_wvalid && bus.mem_wready && (q.size() != 0);
    if (pop) begin
      obs.push_back('{bus.mem_addr, bus.mem_wdata, bus.mem_be});
      last_pop_cyc = cyc;
      n_pop++;
    end
    e   = make_entry(bus.st_addr, bus.st_data, bus.st_sh, bus.st_sw);
    mis = is_misaligned(bus.st_addr, bus.st_sh, bus.st_sw);
    @(posedge clk);
    if (pop) void'(q.pop_front());
    exp_mis = 1'b0;
    if (acc) begin
      if (MIS_CHK && mis) exp_mis = 1'b1;
      else q.push_back(e);
    end
    if (flush_done) pend = 1'b0;
    else if (flush_req) pend = 1'b1;
    last_acc = acc;
    #1;
  endtask

  task automatic set_store(input logic v, input logic [31:0] a, input logic [31:0] d,
                           input logic [2:0] w);
    bus.st_valid = v;
    bus.st_addr  = a;
    bus.st_data  = d;
    {bus.st_sw, bus.st_sh, bus.st_sb} = w;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] w);
    set_store(1'b1, a, d, w);
    tick();
    bus.st_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    bus.mem_wready = 1'b1;
    while ((q.size() != 0 || bus.mem_wvalid) && n < 50) begin
      tick();
      n++;
    end
    chk("drain_timeout", q.size(), 0);
  endtask

  task automatic wait_wvalid();
    int n = 0;
    while (!bus.mem_wvalid && n < 6) begin
      tick();
      n++;
    end
    chk("wvalid_timeout", bus.mem_wvalid, 1);
  endtask

  initial begin
    int n, n0, f0;
    set_store(1'b0, '0, '0, 3'b000);
    bus.mem_wready = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("rst_wvalid", bus.mem_wvalid, 0);
    chk("rst_flush_done", flush_done, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_st_ready", bus.st_ready, 1);
    chk("rst_mem_fields", {bus.mem_addr, bus.mem_wdata, bus.mem_be}, 0);
    chk("rst_ld_hazard", ld_hazard, 0);

    // Word store presented intact.
    store(32'h1000, 32'hDEADBEEF, 3'b100);
    wait_wvalid();
    chk("sw_addr", bus.mem_addr, 32'h1000);
    chk("sw_wdata", bus.mem_wdata, 32'hDEADBEEF);
    chk("sw_be", bus.mem_be, 4'hF);
    drain();

    // Byte then halfword, drained in order.
    obs.delete();
    bus.mem_wready = 1'b1;
    store(32'h2003, 32'h000000A5, 3'b001);
    store(32'h2002, 32'h00001234, 3'b010);
    drain();
    chk("order_count", obs.size(), 2);
    if (obs.size() >= 2) begin
      chk("sb_repl", {obs[0].data, obs[0].be}, {32'hA5A5A5A5, 4'b1000});
      chk("sh_repl", {obs[1].data, obs[1].be}, {32'h12341234, 4'b1100});
    end

    // Fill, then offer one more while draining starts.
    bus.mem_wready = 1'b0;
    for (int i = 0; i < 4; i++) store(32'h6000 + 32'(i * 4), 32'h11110000 + 32'(i), 3'b100);
    chk("full_occ", occupancy, 4);
    chk("full_ready", bus.st_ready, 0);
    n0 = n_pop;
    set_store(1'b1, 32'h6010, 32'h55555555, 3'b100);
    bus.mem_wready = 1'b1;
    n = 0;
    last_acc = 1'b0;
    while (!last_acc && n < 10) begin
      tick();
      n++;
    end
    bus.st_valid = 1'b0;
    chk("full_accept", last_acc, 1);
    chk("pop_before_accept", (n_pop - n0) >= 1, 1);
    drain();

    // Flush with three queued.
    bus.mem_wready = 1'b0;
    for (int i = 0; i < 3; i++) store(32'h7000 + 32'(i * 4), 32'(i), 3'b100);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    chk("flush_blocks", bus.st_ready, 0);
    f0 = fd_cnt;
    bus.mem_wready = 1'b1;
    n = 0;
    while (fd_cnt == f0 && n < 20) begin
      tick();
      n++;
    end
    chk("flush_done_seen", fd_cnt - f0, 1);
    chk("flush_after_pop", fd_cyc - last_pop_cyc, 1);
    tick();
    tick();
    chk("flush_single", fd_cnt - f0, 1);
    chk("flush_ready_back", bus.st_ready, 1);

    // Flush on empty queue.
    f0 = fd_cnt;
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    n = 0;
    while (fd_cnt == f0 && n < 4) begin
      tick();
      n++;
    end
    tick();
    chk("flush_empty", fd_cnt - f0, 1);

    // Load hazard.
    bus.mem_wready = 1'b0;
    ld_addr = 32'h3006;
    store(32'h3004, 32'hCAFE0001, 3'b100);
    tick();
    chk("hazard_hit", ld_hazard, 1);
    ld_addr = 32'h3008;
    tick();
    chk("hazard_miss", ld_hazard, 0);
    ld_addr = 32'h3006;
    drain();
    tick();
    chk("hazard_cleared", ld_hazard, 0);

    // Misaligned word store.
    obs.delete();
    bus.mem_wready = 1'b1;
    store(32'h4002, 32'hCAFEF00D, 3'b100);
`ifdef STORE_MISALIGN_CHK_EN
    chk("misalign_pulse", misalign_err, 1);
    chk("misalign_occ", occupancy, 0);
    tick();
    chk("misalign_once", misalign_err, 0);
`else
    drain();
    chk("force_align_count", obs.size(), 1);
    if (obs.size() >= 1) chk("force_align", {obs[0].addr, obs[0].be}, {32'h4000, 4'hF});
`endif

    // Reset while draining drops everything.
    bus.mem_wready = 1'b0;
    store(32'h8000, 32'h1, 3'b100);
    store(32'h8004, 32'h2, 3'b100);
    wait_wvalid();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_wvalid", bus.mem_wvalid, 0);
    chk("rst_mid_occ", occupancy, 0);
    q.delete();
    pend = 1'b0;
    exp_mis = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      set_store($urandom_range(0, 9) < 6, 32'h5000 + 32'($urandom_range(0, 15)), $urandom,
                3'($urandom_range(0, 7)));
      bus.mem_wready = $urandom_range(0, 3) != 0;
      ld_addr = 32'h5000 + 32'($urandom_range(0, 15));
      flush_req = !pend && ($urandom_range(0, 39) == 0);
      tick();
      flush_req = 1'b0;
    end
    bus.st_valid = 1'b0;
    drain();

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule
